// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin two-port arbiter and
// access sequencer for the shared 64-bit RAM bus.
module ram_bus_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic [63:0] rdata0,
  output logic [63:0] rdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] bus_address,
  output logic [1:0]  bus_size,
  output logic        bus_write,
  output logic        bus_read,
  inout  wire  [63:0] bus_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        last;
  logic        port;
  logic        we_r;
  logic        data_en;
  logic [63:0] wdata_r;
  logic        grant;
  logic        pick;
  logic        finish;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [63:0] sel_wdata;

  // Arbitrate in IDLE, count down the held command in ACCESS
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    pick     = last;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant    = 1'b1;
          pick     = (req0 && req1) ? !last : req1;
          state_nx = ACCESS;
          cnt_nx   = LOAD;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Steer the winning port's request fields onto the bus registers
  always_comb begin
    sel_we    = pick ? we1 : we0;
    sel_addr  = pick ? addr1 : addr0;
    sel_size  = pick ? size1 : size0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // State and access counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered grant, bus command and acknowledge outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last        <= 1'b1;
      port        <= 1'b0;
      we_r        <= 1'b0;
      wdata_r     <= 64'd0;
      data_en     <= 1'b0;
      bus_address <= 32'd0;
      bus_size    <= 2'd0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        last        <= pick;
        port        <= pick;
        we_r        <= sel_we;
        wdata_r     <= sel_wdata;
        data_en     <= sel_we;
        bus_address <= sel_addr;
        bus_size    <= sel_size;
        bus_read    <= !sel_we;
        bus_write   <= sel_we;
        gnt0        <= !pick;
        gnt1        <= pick;
      end
      if (finish) begin
        data_en   <= 1'b0;
        bus_read  <= 1'b0;
        bus_write <= 1'b0;
        ack0      <= !port;
        ack1      <= port;
      end
      if (state == DONE) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
      end
    end
  end

  // Capture read data for the granted port on the last ACCESS edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata0 <= 64'd0;
      rdata1 <= 64'd0;
    end else if (finish && !we_r) begin
      if (port) begin
        rdata1 <= bus_data;
      end else begin
        rdata0 <= bus_data;
      end
    end
  end

  assign bus_data = data_en ? wdata_r : 64'bz;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: two arbiters (1 and 3 access cycles)
// against a transfer-level model and a small RAM.
module tb_ram_bus_arbiter;

  localparam int N = 2;

  logic        clock;
  logic        reset_n;
  logic        req   [N][2];
  logic        we    [N][2];
  logic [31:0] addr  [N][2];
  logic [1:0]  size  [N][2];
  logic [63:0] wdata [N][2];
  logic [63:0] rdata [N][2];
  logic        ack   [N][2];
  logic        gnt   [N][2];
  logic [31:0] badr  [N];
  logic [1:0]  bsz   [N];
  logic        bw    [N];
  logic        br    [N];
  logic [63:0] bd    [N];

  int total = 0;
  int bad = 0;

  // transfer-level reference state
  int          k    [N];
  int          who  [N];
  int          last [N];
  logic        mwe  [N];
  logic [31:0] mad  [N];
  logic [1:0]  msz  [N];
  logic [63:0] mwd  [N];
  logic [63:0] erd  [N][2];
  logic [63:0] mm   [N][16];

  // stimulus knobs
  int          pct [2];
  int          we_pct;
  bit          fix;
  logic        fwe;
  logic [31:0] fad;
  logic [1:0]  fsz;
  logic [63:0] fwd;

  function automatic int ac_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] init_word(int g, int j);
    if (j == 2) return 64'h1122334455667788;
    return {8'hA0 + 8'(g), 8'(j), 48'h5A5A_C3C3_0F0F};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old,
                                        logic [63:0] nw,
                                        logic [1:0] sz);
    logic [63:0] m;
    m = (sz == 2'd3) ? {64{1'b1}}
                     : ((64'd1 << (8 << sz)) - 64'd1);
    return (old & ~m) | (nw & m);
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : gi
    wire  [63:0] bus_data;
    logic [63:0] ram [16];

    initial for (int j = 0; j < 16; j++) ram[j] = init_word(g, j);

    assign bus_data = br[g] ? ram[badr[g][6:3]] : 64'bz;

    always @(posedge clock)
      if (bw[g])
        ram[badr[g][6:3]] <= merge(ram[badr[g][6:3]], bus_data, bsz[g]);

    assign bd[g] = bus_data;

    ram_bus_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 3)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req[g][0]), .req1(req[g][1]),
      .we0(we[g][0]), .we1(we[g][1]),
      .addr0(addr[g][0]), .addr1(addr[g][1]),
      .size0(size[g][0]), .size1(size[g][1]),
      .wdata0(wdata[g][0]), .wdata1(wdata[g][1]),
      .rdata0(rdata[g][0]), .rdata1(rdata[g][1]),
      .ack0(ack[g][0]), .ack1(ack[g][1]),
      .gnt0(gnt[g][0]), .gnt1(gnt[g][1]),
      .bus_address(badr[g]), .bus_size(bsz[g]),
      .bus_write(bw[g]), .bus_read(br[g]),
      .bus_data(bus_data)
    );
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // released bus: Z in 4-state, 0 where undriven nets settle to 0
  task automatic chk_rel(input string tag, input logic [63:0] got);
    total++;
    assert ((got === {64{1'bz}}) || (got === 64'd0)) else begin
      bad++;
      $error("FAIL %s got=%h exp=released", tag, got);
    end
  endtask

  task automatic model_reset(int i);
    k[i] = 0;
    who[i] = 0;
    last[i] = 1;
    erd[i][0] = 64'd0;
    erd[i][1] = 64'd0;
  endtask

  // one clock edge of the transfer-level model
  task automatic advance(int i);
    int p;
    int idx;
    if (k[i] == 0) begin
      if (req[i][0] || req[i][1]) begin
        if (req[i][0] && req[i][1]) p = 1 - last[i];
        else p = req[i][1] ? 1 : 0;
        who[i] = p;
        last[i] = p;
        k[i] = ac_of(i) + 1;
        mwe[i] = we[i][p];
        mad[i] = addr[i][p];
        msz[i] = size[i][p];
        mwd[i] = wdata[i][p];
      end
    end else begin
      idx = int'(mad[i][6:3]);
      if (k[i] > 1 && mwe[i])
        mm[i][idx] = merge(mm[i][idx], mwd[i], msz[i]);
      if (k[i] == 2 && !mwe[i])
        erd[i][who[i]] = mm[i][idx];
      k[i]--;
    end
  endtask

  task automatic check(int i);
    bit acc;
    bit dn;
    string s;
    acc = k[i] > 1;
    dn = k[i] == 1;
    s = $sformatf("i%0d", i);
    for (int p = 0; p < 2; p++) begin
      chk({s, $sformatf(" gnt%0d", p)}, gnt[i][p],
          (k[i] > 0 && who[i] == p));
      chk({s, $sformatf(" ack%0d", p)}, ack[i][p],
          (dn && who[i] == p));
      chk({s, $sformatf(" rdata%0d", p)}, rdata[i][p], erd[i][p]);
    end
    chk({s, " bus_read"}, br[i], acc && !mwe[i]);
    chk({s, " bus_write"}, bw[i], acc && mwe[i]);
    if (!reset_n) begin
      chk({s, " rst addr"}, badr[i], 64'd0);
      chk({s, " rst size"}, bsz[i], 64'd0);
    end
    if (acc) begin
      chk({s, " bus_address"}, badr[i], mad[i]);
      chk({s, " bus_size"}, bsz[i], msz[i]);
    end
    if (acc && mwe[i])
      chk({s, " wr data"}, bd[i], mwd[i]);
    else if (acc)
      chk({s, " rd data"}, bd[i], mm[i][mad[i][6:3]]);
    else
      chk_rel({s, " bus idle"}, bd[i]);
  endtask

  task automatic raise(int i, int p);
    req[i][p] = 1'b1;
    if (fix) begin
      we[i][p] = fwe;
      addr[i][p] = fad;
      size[i][p] = fsz;
      wdata[i][p] = fwd;
    end else begin
      we[i][p] = ($urandom_range(99) < we_pct);
      addr[i][p] = {25'd0, 4'($urandom_range(15)), 3'd0};
      size[i][p] = 2'($urandom_range(3));
      wdata[i][p] = {$urandom, $urandom} | 64'd1;
    end
  endtask

  task automatic drive(int i);
    for (int p = 0; p < 2; p++) begin
      if (ack[i][p] === 1'b1) begin
        req[i][p] = 1'b0;
        if ($urandom_range(99) < pct[p]) raise(i, p);
      end else if (!req[i][p] && $urandom_range(99) < pct[p]) begin
        raise(i, p);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (!reset_n) model_reset(i);
      else advance(i);
      check(i);
      drive(i);
    end
  endtask

  initial begin
    bit found;
    bit prev;
    reset_n = 1'b0;
    pct[0] = 0;
    pct[1] = 0;
    we_pct = 50;
    fix = 1'b0;
    fwe = 1'b0;
    fad = 32'd0;
    fsz = 2'd0;
    fwd = 64'd0;
    for (int i = 0; i < N; i++) begin
      model_reset(i);
      for (int j = 0; j < 16; j++) mm[i][j] = init_word(i, j);
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0;
        we[i][p] = 1'b0;
        addr[i][p] = 32'd0;
        size[i][p] = 2'd0;
        wdata[i][p] = 64'd0;
      end
    end
    repeat (3) step();
    reset_n = 1'b1;

    // 64-bit read of 0x10 on port 0
    fix = 1'b1;
    fwe = 1'b0;
    fad = 32'h10;
    fsz = 2'b11;
    pct[0] = 100;
    repeat (12) step();
    chk("i0 rd 0x10", rdata[0][0], 64'h1122334455667788);
    chk("i1 rd 0x10", rdata[1][0], 64'h1122334455667788);

    // 32-bit write of 0xDEADBEEF to 0x20 on port 1
    pct[0] = 0;
    pct[1] = 100;
    fwe = 1'b1;
    fad = 32'h20;
    fsz = 2'b10;
    fwd = 64'hDEADBEEF;
    repeat (14) step();

    // tie: both requesters held
    fix = 1'b0;
    pct[0] = 100;
    pct[1] = 100;
    repeat (60) step();

    // single requester, back-to-back
    pct[1] = 0;
    repeat (60) step();

    // random traffic, arrivals while busy
    pct[0] = 40;
    pct[1] = 40;
    repeat (400) step();

    // reset in the 2nd ACCESS cycle of a write
    pct[0] = 100;
    pct[1] = 100;
    we_pct = 100;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      prev = bw[1];
      step();
      if (bw[1] && !prev) found = 1'b1;
    end
    chk("wait write", found, 1'b1);
    step();
    we_pct = 50;
    #1 reset_n = 1'b0;
    #1;
    chk("async bus_write", bw[1], 1'b0);
    chk("async bus_read", br[1], 1'b0);
    chk_rel("async bus_data", bd[1]);
    chk("async ack", {ack[1][1], ack[1][0]}, 2'b00);
    chk("async gnt", {gnt[1][1], gnt[1][0]}, 2'b00);
    repeat (3) step();
    reset_n = 1'b1;

    // tie right after reset goes to port 0
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (gnt[1][0] || gnt[1][1]) found = 1'b1;
    end
    chk("tie after reset", {gnt[1][1], gnt[1][0]}, 2'b01);
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
